// File: rtl/rf_wb_arbiter_pkg.sv
// Constants and state encodings shared by the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

  localparam int W    = 8;
  localparam int AW   = 3;
  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2
  } state_t;

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    return {{(NREG-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requests, reservation, quiesce and register-file write signals of the arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [W-1:0]  alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          mem_ready;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          rsv_ready;
  logic          quiesce_req;
  logic          quiesce_ack;
  logic          rf_we;
  logic [AW-1:0] rf_a3;
  logic [W-1:0]  rf_wd;
  logic [NREG-1:0] busy;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           rsv_valid, rsv_addr, quiesce_req,
    input  alu_ready, mem_ready, rsv_ready, quiesce_ack, rf_we, rf_a3, rf_wd, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           rsv_valid, rsv_addr, quiesce_req,
    output alu_ready, mem_ready, rsv_ready, quiesce_ack, rf_we, rf_a3, rf_wd, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, pointer moves to the other requester on each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr=0: requester 0 (ALU) wins a tie; ptr=1: requester 1 wins.
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks; one write per cycle, written the cycle after grant.
// Tracks pending destinations in a busy scoreboard and drains them on a quiesce request.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            rf_we_q;
  logic [AW-1:0]   rf_a3_q;
  logic [W-1:0]    rf_wd_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            rsv_ok;
  logic            ack_q;
  state_t          state;

  // Requests are masked during reset so readies stay low and the pointer is untouched.
  assign req = {bus.mem_valid, bus.alu_valid} & {2{reset}};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];

  assign rsv_ok        = reset && (state == RUN) && !busy_q[bus.rsv_addr];
  assign bus.rsv_ready = rsv_ok;

  assign set_mask = (bus.rsv_valid && rsv_ok) ? onehot(bus.rsv_addr) : '0;
  assign clr_mask = rf_we_q ? onehot(rf_a3_q) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= |gnt;
      if (gnt[0]) begin
        rf_a3_q <= bus.alu_addr;
        rf_wd_q <= bus.alu_data;
      end else if (gnt[1]) begin
        rf_a3_q <= bus.mem_addr;
        rf_wd_q <= bus.mem_data;
      end
    end
  end

  // A new reservation outranks a completing write to the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      ack_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.quiesce_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.quiesce_req) begin
            state <= RUN;
          end else if (busy_q == '0 && !rf_we_q && !bus.alu_valid && !bus.mem_valid) begin
            state <= QUIET;
            ack_q <= 1'b1;
          end
        end
        QUIET: begin
          if (!bus.quiesce_req) begin
            state <= RUN;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_a3       = rf_a3_q;
  assign bus.rf_wd       = rf_wd_q;
  assign bus.busy        = busy_q;
  assign bus.quiesce_ack = ack_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (WE/A3/data) between two writeback requesters: ALU result and memory load.
- Keeps a per-register busy scoreboard so decode can reserve destinations and detect hazards.
- Provides a quiesce handshake so the control unit can drain all outstanding writes before halting or reconfiguring.
- Sits between the execute/memory stages and register_file.

Parameters:
- W, 8, data width of register file words.
- AW, 3, register address width.
- NREG, 8, number of registers (2**AW).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_addr  in  AW  load destination register.
- mem_data  in  W  load data.
- mem_ready  out  1  load request accepted this cycle.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  AW  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- quiesce_req  in  1  control requests drain.
- quiesce_ack  out  1  all writes drained; block is quiet.
- rf_we  out  1  to register_file WE.
- rf_a3  out  AW  to register_file A3.
- rf_wd  out  W  to register_file data.
- busy  out  NREG  scoreboard, bit i set = write to register i pending.

Behaviour:
- Reset (reset=0, asynchronous): rf_we=0, rf_a3=0, rf_wd=0, busy=0, round-robin pointer = ALU, FSM=RUN, quiesce_ack=0. Ready outputs are combinational and are 0 while in reset.
- Handshake: a transfer occurs when valid&&ready. A requester holds valid, addr and data stable until accepted. Ready never depends on the same requester's own data.
- Arbitration (combinational, every cycle):
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last is granted, then the pointer flips.
  - Pointer changes only on a grant.
- Latency: a grant in cycle N registers addr/data, and rf_we=1 with rf_a3/rf_wd is driven in cycle N+1 for exactly one cycle. Throughput is 1 write per cycle. With no grant in cycle N, rf_we=0 in N+1.
- Same address from both requesters in one cycle: arbitrated normally; the loser is written the following cycle, so last writer wins.
- Scoreboard:
  - rsv_ready = ~busy[rsv_addr] && FSM==RUN.
  - An accepted reservation sets busy[rsv_addr] at the next edge.
  - The edge where rf_we=1 clears busy[rf_a3].
  - Set and clear on the same address at the same edge: set wins (the new producer owns the register).
  - A writeback to a non-busy register is legal; busy stays 0.
- FSM:
  - RUN: normal operation. quiesce_req=1 -> DRAIN.
  - DRAIN: reservations refused (rsv_ready=0); writebacks still granted. When busy==0, rf_we==0, alu_valid==0 and mem_valid==0 -> QUIET.
  - QUIET: quiesce_ack=1 (registered, asserted the cycle after entry); rsv_ready=0; writebacks still accepted. quiesce_req=0 -> RUN, with quiesce_ack low in the same transition edge.
  - quiesce_req dropped while in DRAIN -> RUN.
- Reset mid-operation: a pending output write is discarded (rf_we forced 0 asynchronously) and busy is cleared.

Decomposition:
- Shared package/header (processor-wide constants): W, AW, NREG, and FSM state encodings RUN=2'd0, DRAIN=2'd1, QUIET=2'd2.
- One sub-module, rr_arb2: the 2-way round-robin arbiter. Inputs req[1:0]; outputs gnt[1:0]; holds the pointer internally.
- Scoreboard, output register and FSM stay in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both valids=1 -> rf_we=0, busy=8'h00, alu_ready=mem_ready=0, quiesce_ack=0.
- Single write: alu_valid=1, alu_addr=3, alu_data=8'hA5 in cycle N -> alu_ready=1 in N; rf_we=1, rf_a3=3, rf_wd=8'hA5 in N+1; rf_we=0 in N+2.
- Contention:
  - Both valid for 4 cycles: alu (addr 1, 8'h11) and mem (addr 2, 8'h22); after each grant the requester presents its next item.
  - Required: grants alternate ALU, MEM, ALU, MEM starting with ALU after reset.
  - Required: rf_a3 sequence 1,2,1,2 on consecutive cycles with no bubbles.
- Scoreboard:
  - Reserve addr 5 -> busy=8'h20.
  - Second reserve of addr 5 -> rsv_ready=0.
  - mem write to addr 5 -> busy returns to 8'h00 on the edge where rf_we=1.
  - Simultaneous reserve of 5 and rf_we to 5 -> busy[5] stays 1.
- Quiesce:
  - Reserve reg 4, then raise quiesce_req -> rsv_ready=0 and quiesce_ack=0.
  - ALU write to reg 4 completes -> quiesce_ack=1 two cycles after that rf_we.
  - Drop quiesce_req -> quiesce_ack=0 and rsv_ready=1 next cycle.
- Async reset mid-write: assert reset low between edges while rf_we=1 and busy=8'h10 -> rf_we=0 and busy=8'h00 immediately, without waiting for clk.
